regfile_operand_fetch: RTL and testbench

Operand-fetch sequencer that sits directly downstream of the 32x32 register file. It accepts a decoded instruction's source register pair, and reads both operands through the register file's single combinational read port (select/dout) over two consecutive cycles. It bypasses writebacks that land in the same cycle and presents the operand pair to the execute stage with a valid/ready handshake. Register x0 always reads as zero.

---
 rtl/regfile_operand_fetch_if.sv | 32 +++
 rtl/regfile_operand_fetch.sv | 131 +++++++++++++
 tb/tb_regfile_operand_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_operand_fetch_if.sv
// Operand-fetch bus: request side, register-file read port, writeback snoop
// and the operand handshake toward execute.
//   slave  : the operand-fetch block (regfile_operand_fetch)
//   master : the surrounding pipeline / register file
interface regfile_operand_fetch_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rf_select;
    logic [XLEN-1:0] rf_dout;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    modport slave (
        input  req_valid, rs1, rs2, rf_dout, wb_en, wb_addr, wb_data, op_ready,
        output req_ready, rf_select, op_valid, op_a, op_b
    );

    modport master (
        output req_valid, rs1, rs2, rf_dout, wb_en, wb_addr, wb_data, op_ready,
        input  req_ready, rf_select, op_valid, op_a, op_b
    );
endinterface

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch sequencer: reads rs1 then rs2 through the register file's
// single combinational read port, bypasses same-cycle writebacks, tracks
// writebacks into captured operands until the execute handshake completes.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_operand_fetch_if.slave (request, rf read, writeback,
//                operand valid/ready)
module regfile_operand_fetch #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic            op_valid_q;

    logic            req_ready_c;
    logic            accept_c;
    logic            wb_hit_a_c;
    logic            wb_hit_b_c;
    logic [XLEN-1:0] cap_a_c;
    logic [XLEN-1:0] cap_b_c;
    logic [AW-1:0]   rf_select_c;

    // Handshake and read-port address depend only on state and op_ready.
    always_comb begin
        req_ready_c = 1'b0;
        rf_select_c = AW'(0);
        case (state)
            IDLE:    req_ready_c = 1'b1;
            READ_A:  rf_select_c = rs1_q;
            READ_B:  rf_select_c = rs2_q;
            HOLD:    req_ready_c = bus.op_ready;
            default: req_ready_c = 1'b0;
        endcase
        if (reset) begin
            req_ready_c = 1'b0;
        end
        accept_c = bus.req_valid && req_ready_c;
    end

    // Writeback hits on x0 are ignored; the file has not yet absorbed a hit,
    // so a hit overrides rf_dout.
    always_comb begin
        wb_hit_a_c = bus.wb_en && (bus.wb_addr == rs1_q) && (rs1_q != AW'(0));
        wb_hit_b_c = bus.wb_en && (bus.wb_addr == rs2_q) && (rs2_q != AW'(0));
        cap_a_c    = bus.rf_dout;
        cap_b_c    = bus.rf_dout;
        if (rs1_q == AW'(0)) begin
            cap_a_c = XLEN'(0);
        end else if (wb_hit_a_c) begin
            cap_a_c = bus.wb_data;
        end
        if (rs2_q == AW'(0)) begin
            cap_b_c = XLEN'(0);
        end else if (wb_hit_b_c) begin
            cap_b_c = bus.wb_data;
        end
    end

    // Sequencer state, latched indices and operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rs1_q      <= AW'(0);
            rs2_q      <= AW'(0);
            op_a_q     <= XLEN'(0);
            op_b_q     <= XLEN'(0);
            op_valid_q <= 1'b0;
        end else begin
            if (accept_c) begin
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
            end
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state <= READ_A;
                    end
                end
                READ_A: begin
                    op_a_q <= cap_a_c;
                    state  <= READ_B;
                end
                READ_B: begin
                    op_b_q     <= cap_b_c;
                    op_valid_q <= 1'b1;
                    state      <= HOLD;
                    if (wb_hit_a_c) begin
                        op_a_q <= bus.wb_data;
                    end
                end
                HOLD: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state      <= accept_c ? READ_A : IDLE;
                    end else begin
                        if (wb_hit_a_c) begin
                            op_a_q <= bus.wb_data;
                        end
                        if (wb_hit_b_c) begin
                            op_b_q <= bus.wb_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rf_select = rf_select_c;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 32x32
// register file (combinational read, write at the rising edge).
module tb_regfile_operand_fetch;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] regs [32];

    regfile_operand_fetch_if #(.XLEN(32), .AW(5)) bus ();

    regfile_operand_fetch #(.XLEN(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model file stores x0 writes too, so the DUT must force x0 to zero.
    assign bus.rf_dout = regs[bus.rf_select];
    always_ff @(posedge clk) begin
        if (bus.wb_en) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        step();
        bus.wb_en   = 1'b0;
    endtask

    task automatic request(input logic [4:0] a, input logic [4:0] b);
        bus.req_valid = 1'b1;
        bus.rs1       = a;
        bus.rs2       = b;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'd0;
        bus.op_ready  = 1'b1;

        // Reset state
        step();
        step();
        check("rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("rst_op_a", bus.op_a, 32'd0);
        check("rst_op_b", bus.op_b, 32'd0);
        check("rst_rf_select", 32'(bus.rf_select), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Preload the register file
        wb_write(5'd5, 32'h0000_1234);
        wb_write(5'd9, 32'h0000_ABCD);
        wb_write(5'd3, 32'h0000_0042);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd4, 32'h0000_0011);

        // Basic read
        request(5'd5, 5'd9);
        check("basic_sel_a", 32'(bus.rf_select), 32'd5);
        check("basic_ready_ra", 32'(bus.req_ready), 32'd0);
        check("basic_valid_ra", 32'(bus.op_valid), 32'd0);
        step();
        check("basic_sel_b", 32'(bus.rf_select), 32'd9);
        check("basic_valid_rb", 32'(bus.op_valid), 32'd0);
        step();
        check("basic_valid", 32'(bus.op_valid), 32'd1);
        check("basic_op_a", bus.op_a, 32'h0000_1234);
        check("basic_op_b", bus.op_b, 32'h0000_ABCD);
        check("basic_sel_hold", 32'(bus.rf_select), 32'd0);
        step();
        check("basic_done", 32'(bus.op_valid), 32'd0);

        // Bypass: write lands during READ_A, both operands see it
        request(5'd7, 5'd7);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h55AA_55AA;
        step();
        bus.wb_en   = 1'b0;
        step();
        check("byp_valid", 32'(bus.op_valid), 32'd1);
        check("byp_op_a", bus.op_a, 32'h55AA_55AA);
        check("byp_op_b", bus.op_b, 32'h55AA_55AA);
        step();

        // Zero register with a concurrent write to x0
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'hFFFF_FFFF;
        request(5'd0, 5'd3);
        step();
        step();
        check("zero_op_a", bus.op_a, 32'd0);
        check("zero_op_b", bus.op_b, 32'h0000_0042);
        bus.wb_en = 1'b0;
        step();

        // Backpressure with writeback tracking
        bus.op_ready = 1'b0;
        request(5'd2, 5'd4);
        step();
        step();
        check("bp_valid0", 32'(bus.op_valid), 32'd1);
        check("bp_op_b0", bus.op_b, 32'h0000_0011);
        wb_write(5'd4, 32'h0000_0099);
        check("bp_op_b_track", bus.op_b, 32'h0000_0099);
        check("bp_op_a_keep", bus.op_a, 32'h0000_0022);
        check("bp_valid1", 32'(bus.op_valid), 32'd1);
        check("bp_ready", 32'(bus.req_ready), 32'd0);
        wb_write(5'd2, 32'h0000_2222);
        check("bp_op_a_track", bus.op_a, 32'h0000_2222);
        wb_write(5'd0, 32'h0000_0BAD);
        check("bp_x0_ignored_b", bus.op_b, 32'h0000_0099);
        check("bp_valid3", 32'(bus.op_valid), 32'd1);
        bus.op_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(bus.req_ready), 32'd1);
        step();
        check("bp_done", 32'(bus.op_valid), 32'd0);

        // Back-to-back: one pair every 3 cycles, HOLD goes straight to READ_A
        bus.req_valid = 1'b1;
        bus.rs1       = 5'd5;
        bus.rs2       = 5'd9;
        step();
        for (int i = 0; i < 9; i++) begin
            check("b2b_valid", 32'(bus.op_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            check("b2b_sel", 32'(bus.rf_select),
                  (i % 3 == 0) ? 32'd5 : ((i % 3 == 1) ? 32'd9 : 32'd0));
            if (i % 3 == 2) begin
                check("b2b_op_a", bus.op_a, 32'h0000_1234);
                check("b2b_op_b", bus.op_b, 32'h0000_ABCD);
            end
            step();
        end
        bus.req_valid = 1'b0;
        step();
        step();
        step();
        check("b2b_drain_idle", 32'(bus.req_ready), 32'd1);

        // Reset during READ_B abandons the request
        request(5'd5, 5'd9);
        step();
        check("rstmid_sel_b", 32'(bus.rf_select), 32'd9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rstmid_valid", 32'(bus.op_valid), 32'd0);
        check("rstmid_idle", 32'(bus.req_ready), 32'd1);
        check("rstmid_sel", 32'(bus.rf_select), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_no_pulse", 32'(bus.op_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
